// File: rtl/uart_rx.sv
// Purpose : UART receiver, 16x oversampled; deserialises start + DBIT data (LSB first) + stop.
// Latency : i_rx reaches the FSM after 2 clocks; o_rx_done fires on the final stop tick.
// Backpressure: none; o_dout/o_frame_err hold until the next frame overwrites them.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_rx         serial line, idle high, asynchronous to i_clk
//   i_s_tick     one-clock pulse at 16x the baud rate
//   o_dout       last received data word
//   o_rx_done    one-clock pulse when a frame completes
//   o_frame_err  stop sample of the last completed frame was low
//   o_busy       receiver is inside a frame (state != IDLE)
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_s_tick,
    output logic [DBIT-1:0] o_dout,
    output logic            o_rx_done,
    output logic            o_frame_err,
    output logic            o_busy
);

    // Tick counter must reach SB_TICK-1 in STOP, and 15 in DATA.
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = ($clog2(DBIT) > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_ONE      = SW'(1);
    localparam logic [SW-1:0] S_MID      = SW'(7);
    localparam logic [SW-1:0] S_BIT_END  = SW'(15);
    localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_ONE      = NW'(1);
    localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            rx_meta, rx_s;
    logic            done_d;

    // Two-flop synchroniser; resets to the idle (high) line level so a
    // reset release never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        case (state_q)
            // Start detection does not wait for a tick.
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            // Re-check the line half a bit in; a high level there was a glitch.
            START: begin
                if (i_s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            // Sample every 16 ticks from the start-bit centre, i.e. at bit centres.
            DATA: begin
                if (i_s_tick) begin
                    if (s_q == S_BIT_END) begin
                        s_d     = '0;
                        shift_d = {rx_s, shift_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + N_ONE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            // Leaving on the final stop tick lets a following start bit be
            // caught on the very next clock.
            STOP: begin
                if (i_s_tick) begin
                    if (s_q == S_STOP_END) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_dout      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done <= done_d;
            if (done_d) begin
                o_dout      <= shift_q;
                o_frame_err <= ~rx_s;
            end
        end
    end

    assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Purpose : directed self-checking bench for uart_rx (DBIT=8/SB_TICK=16 and DBIT=7/SB_TICK=32).
// Latency : frames are timed in oversampling ticks from a mod-M tick generator.
// Backpressure: none; completed frames are logged by a monitor and checked by each test.
module tb_uart_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rx1, rx2;
    logic       s_tick;
    logic [7:0] dout1;
    logic       done1, err1, busy1;
    logic [6:0] dout2;
    logic       done2, err2, busy2;

    int n_cmp = 0;
    int n_bad = 0;

    int tick_m    = 8;
    int tick_cnt  = 0;
    int tcount    = 0;
    int last_tick = 0;
    int ref_t     = 0;

    logic [7:0] d1_q[$];
    logic       e1_q[$];
    int         t1_q[$];
    int         hi1 = 0;
    logic       prev1 = 1'b0;
    logic [6:0] d2_q[$];
    logic       e2_q[$];
    int         t2_q[$];
    int         hi2 = 0;
    logic       prev2 = 1'b0;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_rx(rx1), .i_s_tick(s_tick),
        .o_dout(dout1), .o_rx_done(done1), .o_frame_err(err1), .o_busy(busy1)
    );

    uart_rx #(.DBIT(7), .SB_TICK(32)) dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_rx(rx2), .i_s_tick(s_tick),
        .o_dout(dout2), .o_rx_done(done2), .o_frame_err(err2), .o_busy(busy2)
    );

    // Mod-M baud tick generator; tcount numbers the tick seen at the next rising edge.
    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_cnt >= tick_m - 1) tick_cnt = 0;
            else tick_cnt = tick_cnt + 1;
            s_tick = (tick_cnt == 0);
            if (s_tick) tcount = tcount + 1;
        end
    end

    // Log every completed frame with the tick index of its completing tick.
    always @(posedge clk) begin
        #1;
        if (done1 === 1'b1) begin
            hi1 = hi1 + 1;
            if (prev1 !== 1'b1) begin
                d1_q.push_back(dout1); e1_q.push_back(err1); t1_q.push_back(tcount);
            end
        end
        prev1 = done1;
        if (done2 === 1'b1) begin
            hi2 = hi2 + 1;
            if (prev2 !== 1'b1) begin
                d2_q.push_back(dout2); e2_q.push_back(err2); t2_q.push_back(tcount);
            end
        end
        prev2 = done2;
    end

    task automatic wait_tick();
        do @(posedge clk); while (s_tick !== 1'b1);
        last_tick = tcount;
    endtask

    task automatic send_bit(input logic sel, input logic b, input int nt);
        @(negedge clk);
        if (sel) rx2 = b;
        else rx1 = b;
        repeat (nt) wait_tick();
    endtask

    task automatic send_frame(input logic sel, input logic [7:0] data, input int nbits,
                              input logic stop_v, input int stop_n, output int start_t);
        start_t = last_tick;
        send_bit(sel, 1'b0, 16);
        for (int i = 0; i < nbits; i++) send_bit(sel, data[i], 16);
        send_bit(sel, stop_v, stop_n);
    endtask

    task automatic clear_logs();
        d1_q.delete(); e1_q.delete(); t1_q.delete(); hi1 = 0;
        d2_q.delete(); e2_q.delete(); t2_q.delete(); hi2 = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (dout1 !== 8'h00) begin n_bad++; $display("FAIL reset_dout got %0h want 0", dout1); end
        n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done1); end
        n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b want 0", err1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy1); end
        n_cmp++; if (dout2 !== 7'h00) begin n_bad++; $display("FAIL reset_dout2 got %0h want 0", dout2); end
        @(negedge clk);
        rst_n = 1'b1;
        send_bit(1'b0, 1'b1, 4);
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got %0b want 0", busy1); end
        n_cmp++; if (d1_q.size() != 0) begin n_bad++; $display("FAIL post_reset_done got %0d want 0", d1_q.size()); end
    endtask

    task automatic test_glitch();
        clear_logs();
        send_bit(1'b0, 1'b0, 4);
        n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_in got %0b want 1", busy1); end
        send_bit(1'b0, 1'b1, 16);
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_out got %0b want 0", busy1); end
        n_cmp++; if (d1_q.size() != 0) begin n_bad++; $display("FAIL glitch_done got %0d want 0", d1_q.size()); end
        n_cmp++; if (dout1 !== 8'h00) begin n_bad++; $display("FAIL glitch_dout got %0h want 0", dout1); end
    endtask

    task automatic test_basic();
        tick_m = 163;
        send_bit(1'b0, 1'b1, 2);
        clear_logs();
        send_frame(1'b0, 8'hA5, 8, 1'b1, 16, ref_t);
        send_bit(1'b0, 1'b1, 4);
        n_cmp++; if (d1_q.size() != 1) begin n_bad++; $display("FAIL basic_count got %0d want 1", d1_q.size()); end
        if (d1_q.size() >= 1) begin
            n_cmp++; if (d1_q[0] !== 8'hA5) begin n_bad++; $display("FAIL basic_dout got %0h want a5", d1_q[0]); end
            n_cmp++; if (e1_q[0] !== 1'b0) begin n_bad++; $display("FAIL basic_err got %0b want 0", e1_q[0]); end
            n_cmp++; if (t1_q[0] - ref_t != 152) begin n_bad++; $display("FAIL basic_tick got %0d want 152", t1_q[0] - ref_t); end
        end
        n_cmp++; if (hi1 != 1) begin n_bad++; $display("FAIL basic_pulse_width got %0d want 1", hi1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL basic_busy got %0b want 0", busy1); end
        tick_m = 8;
        send_bit(1'b0, 1'b1, 2);
    endtask

    task automatic test_frame_err();
        clear_logs();
        // Stop bit held low only part way, so the line is high again before
        // the receiver's half-bit start re-check.
        send_frame(1'b0, 8'h3C, 8, 1'b0, 12, ref_t);
        send_bit(1'b0, 1'b1, 24);
        n_cmp++; if (d1_q.size() != 1) begin n_bad++; $display("FAIL ferr_count got %0d want 1", d1_q.size()); end
        if (d1_q.size() >= 1) begin
            n_cmp++; if (d1_q[0] !== 8'h3C) begin n_bad++; $display("FAIL ferr_dout got %0h want 3c", d1_q[0]); end
            n_cmp++; if (e1_q[0] !== 1'b1) begin n_bad++; $display("FAIL ferr_err got %0b want 1", e1_q[0]); end
        end
        n_cmp++; if (dout1 !== 8'h3C) begin n_bad++; $display("FAIL ferr_hold got %0h want 3c", dout1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL ferr_busy got %0b want 0", busy1); end
        clear_logs();
        send_frame(1'b0, 8'h81, 8, 1'b1, 16, ref_t);
        send_bit(1'b0, 1'b1, 4);
        n_cmp++; if (d1_q.size() != 1) begin n_bad++; $display("FAIL good_count got %0d want 1", d1_q.size()); end
        if (d1_q.size() >= 1) begin
            n_cmp++; if (d1_q[0] !== 8'h81) begin n_bad++; $display("FAIL good_dout got %0h want 81", d1_q[0]); end
        end
        n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL good_err got %0b want 0", err1); end
    endtask

    task automatic test_back_to_back();
        int d;
        clear_logs();
        send_frame(1'b0, 8'h00, 8, 1'b1, 16, ref_t);
        send_frame(1'b0, 8'hFF, 8, 1'b1, 16, ref_t);
        send_bit(1'b0, 1'b1, 4);
        n_cmp++; if (d1_q.size() != 2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", d1_q.size()); end
        if (d1_q.size() >= 2) begin
            n_cmp++; if (d1_q[0] !== 8'h00) begin n_bad++; $display("FAIL b2b_dout0 got %0h want 0", d1_q[0]); end
            n_cmp++; if (d1_q[1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_dout1 got %0h want ff", d1_q[1]); end
            n_cmp++; if ((e1_q[0] | e1_q[1]) !== 1'b0) begin n_bad++; $display("FAIL b2b_err got %0b%0b want 00", e1_q[0], e1_q[1]); end
            d = t1_q[1] - t1_q[0];
            n_cmp++; if (d < 159 || d > 161) begin n_bad++; $display("FAIL b2b_gap got %0d ticks want 160", d); end
        end
        n_cmp++; if (hi1 != 2) begin n_bad++; $display("FAIL b2b_pulse_width got %0d high clocks want 2", hi1); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        v = 8'h5A;
        clear_logs();
        send_bit(1'b0, 1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(1'b0, v[i], 16);
        send_bit(1'b0, v[4], 8);
        n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before got %0b want 1", busy1); end
        @(negedge clk);
        rx1 = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %0b want 0", busy1); end
        n_cmp++; if (dout1 !== 8'h00) begin n_bad++; $display("FAIL rmid_dout got %0h want 0", dout1); end
        n_cmp++; if ({done1, err1} !== 2'b00) begin n_bad++; $display("FAIL rmid_flags got %0b want 00", {done1, err1}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_bit(1'b0, 1'b1, 24);
        n_cmp++; if (d1_q.size() != 0) begin n_bad++; $display("FAIL rmid_no_done got %0d want 0", d1_q.size()); end
        send_frame(1'b0, 8'h5A, 8, 1'b1, 16, ref_t);
        send_bit(1'b0, 1'b1, 4);
        n_cmp++; if (d1_q.size() != 1) begin n_bad++; $display("FAIL rmid_after_count got %0d want 1", d1_q.size()); end
        if (d1_q.size() >= 1) begin
            n_cmp++; if (d1_q[0] !== 8'h5A) begin n_bad++; $display("FAIL rmid_after_dout got %0h want 5a", d1_q[0]); end
        end
    endtask

    task automatic test_dbit7();
        clear_logs();
        send_frame(1'b1, 8'h55, 7, 1'b1, 32, ref_t);
        send_bit(1'b1, 1'b1, 4);
        n_cmp++; if (d2_q.size() != 1) begin n_bad++; $display("FAIL d7_count got %0d want 1", d2_q.size()); end
        if (d2_q.size() >= 1) begin
            n_cmp++; if (d2_q[0] !== 7'h55) begin n_bad++; $display("FAIL d7_dout got %0h want 55", d2_q[0]); end
            n_cmp++; if (e2_q[0] !== 1'b0) begin n_bad++; $display("FAIL d7_err got %0b want 0", e2_q[0]); end
            // Last data sample lands on tick 8+16*7=120; two stop bits add 32.
            n_cmp++; if (t2_q[0] - ref_t != 152) begin n_bad++; $display("FAIL d7_tick got %0d want 152", t2_q[0] - ref_t); end
        end
        n_cmp++; if (hi2 != 1) begin n_bad++; $display("FAIL d7_pulse_width got %0d want 1", hi2); end
        n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL d7_busy got %0b want 0", busy2); end
        n_cmp++; if (d1_q.size() != 0) begin n_bad++; $display("FAIL d7_other_rx got %0d want 0", d1_q.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        rx1   = 1'b1;
        rx2   = 1'b1;
        test_reset();
        test_glitch();
        test_basic();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_dbit7();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver with 16x oversampling.
- Sits directly downstream of the baud-rate mod-M counter: its `i_s_tick` input is driven by that counter's max-tick output, which pulses once per 1/16 bit period.
- Samples the serial line, deserialises one frame (start, DBIT data bits LSB-first, stop), and presents the byte with a one-clock done pulse and a frame-error flag to the RX FIFO/interface stage.

Parameters:
- DBIT, 8, number of data bits per frame (5..8).
- SB_TICK, 16, oversampling ticks in the stop interval (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- i_clk, input, 1, system clock; all logic on rising edge.
- i_reset, input, 1, asynchronous active-low reset (0 = reset).
- i_rx, input, 1, serial line; idle high; asynchronous to i_clk.
- i_s_tick, input, 1, oversampling tick; one-clock pulse at 16x baud.
- o_dout, output, DBIT, last received data word.
- o_rx_done, output, 1, one-clock pulse when a frame completes.
- o_frame_err, output, 1, stop sample of the last completed frame was 0.
- o_busy, output, 1, high while state is not IDLE.

Behaviour:
- Reset, asynchronous while i_reset=0, values held until release:
  - state=IDLE; tick counter s=0; bit counter n=0; shift register=0.
  - Both synchroniser flops=1.
  - o_dout=0, o_rx_done=0, o_frame_err=0, o_busy=0.
- Input synchroniser:
  - i_rx passes through 2 flops (rx_s).
  - All decisions use rx_s, so latency from i_rx to state logic is 2 clocks.
- Counters:
  - s is 4 bits for DBIT data sampling; in STOP it counts to SB_TICK-1, so it is sized ceil(log2(SB_TICK)), minimum 4.
  - n is ceil(log2(DBIT)) bits.
  - Counters and states change only in cycles with i_s_tick=1, except the IDLE->START transition.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s=0 -> START with s=0; tick is not required.
  - START: on tick:
    - if s==7 and rx_s==0 -> DATA, s=0, n=0 (mid-start-bit confirm).
    - if s==7 and rx_s==1 -> IDLE (glitch rejected; no done, no error).
    - otherwise s=s+1.
  - DATA: on tick:
    - if s==15: s=0, shift = {rx_s, shift[DBIT-1:1]} (LSB first).
    - then if n==DBIT-1 -> STOP, else n=n+1.
    - otherwise s=s+1.
  - STOP: on tick:
    - if s==SB_TICK-1 -> IDLE.
    - otherwise s=s+1.
- Frame completion, on the clock edge that leaves STOP:
  - o_dout <= shift register.
  - o_frame_err <= ~rx_s.
  - o_rx_done <= 1 for exactly one clock.
  - o_dout and o_frame_err then hold until the next completion.
- Sample points:
  - Each data bit is sampled at tick 16 after the previous sample point, i.e. the bit centre.
  - The stop sample is taken at the final STOP tick.
- Back-to-back frames:
  - IDLE is re-entered on the last STOP tick.
  - A start bit already low at that point is detected on the next clock.
  - No idle gap is required.
- o_busy = (state != IDLE), registered with the state.
- i_s_tick held high continuously: every clock counts as a tick; behaviour is still well-defined.
- Reset mid-frame: the partial frame is discarded and no o_rx_done is issued. The first frame after release is received normally.

Test Plan:
- Baud counter M=163 driving i_s_tick; send 0xA5 LSB-first with stop=1 -> o_rx_done pulses exactly 1 clock; o_dout=0xA5; o_frame_err=0; o_busy low afterwards.
- Low glitch of 4 tick periods on an idle line -> FSM returns to IDLE at START s==7; no o_rx_done; o_dout unchanged (0x00 after reset).
- Send 0x3C with stop bit driven 0 -> o_rx_done pulses; o_dout=0x3C; o_frame_err=1. Next good frame 0x81 -> o_frame_err=0.
- Back-to-back frames 0x00 then 0xFF, no idle gap -> two o_rx_done pulses about 160 ticks apart; o_dout=0x00 then 0xFF.
- Assert i_reset=0 during data bit 4 of 0x5A -> o_busy=0 and all outputs 0 immediately; no done. After release, send 0x5A -> o_dout=0x5A.
- DBIT=7, SB_TICK=32; send 0x55 with 2 stop bits -> o_dout=0x55; o_rx_done occurs 32 ticks after the last data sample.
